encrypt_core: RTL and testbench
===============================

# encrypt_core

Iterative AES encryption engine: the forward counterpart of the decryption datapath. The block accepts one 128-bit plaintext block on a start pulse and applies the initial AddRoundKey. It then performs nr-1 full rounds and one final round (no MixColumns), one round per clock, using a precomputed key schedule. It sits beside the decryption engine and shares its key-schedule bus format and addRoundKey primitive.

## Interface
- nk, 4, key length in 32-bit words (4/6/8); informational for the key-schedule width.
- nr, 10, number of rounds (10/12/14); sets round-counter range and keySchedule width.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; clears all state immediately on assertion.
- start  input  1  request to encrypt Message; sampled only in IDLE.
- Message  input  [0:127]  plaintext; bit 0 = MSB of byte 0 (FIPS-197 byte order).
- keySchedule  input  [0:128*(nr+1)-1]  round keys; round key r = keySchedule[128*r +:128], r = 0..nr.
- busy  output  1  high while a block is in flight.
- done  output  1  one-cycle pulse: cipher holds a new result.
- cipher  output  [0:127]  ciphertext; held until the next completion.

## Operation
- Datapath: 128-bit stateReg, 4-bit-or-wider round counter rnd (wide enough for nr = 14), output register cipher.
- Round logic, combinational from stateReg: SubBytes (S-box, 16 instances), ShiftRows, MixColumns (GF(2^8), poly 0x11B, xtime), then addRoundKey with key rnd. Final round omits MixColumns.
- FSM states: IDLE, RUN.
  - IDLE, start=1: stateReg <= Message XOR key 0; rnd <= 1; busy <= 1; go to RUN. Message is captured at this edge only.
  - IDLE, start=0: hold; stateReg and cipher unchanged.
  - RUN, rnd < nr: stateReg <= full round(stateReg, key rnd); rnd <= rnd+1.
  - RUN, rnd == nr: cipher <= final round(stateReg, key nr); done <= 1; busy <= 0; rnd <= 0; go to IDLE.
- done is forced to 0 on every edge except the completing one.
- start while busy=1 is ignored; it is not queued.
- start in the cycle where done=1 (FSM is already in IDLE) is accepted, giving back-to-back blocks with no bubble.
- keySchedule must be stable from the accepting edge through the completing edge; it is not latched.
- Reset low at any time, including mid-operation: FSM to IDLE, rnd=0, stateReg=0, cipher=0, busy=0, done=0. The in-flight block is discarded and no done is produced. Operation resumes on the first rising edge after reset is deasserted.

## Timing
- Reset values: busy=0, done=0, cipher=128'h0.
- start sampled at edge E0. busy is high after E0 through edge E0+nr. At edge E0+nr, busy falls, done rises, and cipher updates.
- Latency: nr+1 edges from acceptance to the result being visible (11 for AES-128), counting E0.
- Throughput: one block per nr+1 cycles with start held high continuously.
- done width: exactly 1 cycle. cipher is stable from E0+nr until the next completion or reset.
- No combinational path from inputs to outputs; all outputs are registered.

## Test plan
- FIPS-197 C.1 (nr=10): Message 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f expanded; start for 1 cycle -> done exactly 11 edges after acceptance; cipher = 69c4e0d86a7b0430d8cdb78070b4c55a; busy high for 10 cycles. Internal stateReg after the accepting edge = 00102030405060708090a0b0c0d0e0f0.
- FIPS-197 B: Message 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c -> cipher 3925841d02dc09fbdc118597196a0b32.
- Back-to-back: start held high across both vectors above -> two done pulses 11 cycles apart with the correct ciphers. start pulses injected mid-run cause no extra done pulse and no corruption.
- Reset mid-operation: assert reset at round 5 of C.1 -> busy, done and cipher go to 0 immediately (asynchronous). Restart after release -> correct C.1 result with full latency.
- Idle hold: no start for 50 cycles after a result -> cipher unchanged, done=0, busy=0.
- Parameter sweep: nr=14, nk=8, FIPS-197 C.3 (key 000102...1e1f, same plaintext as C.1) -> cipher 8ea2b7ca516745bfeafc49904b496089 with 15-edge latency.

Source files
------------

// File: rtl/encrypt_core.sv
// Iterative AES block encryptor: one round per clock from a precomputed key schedule.
// Round keys are indexed in FIPS-197 byte order (bit 0 is the MSB of byte 0).
module encrypt_core #(
  parameter int unsigned nk = 4,
  parameter int unsigned nr = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [0:127]            Message,
  input  logic [0:128*(nr+1)-1]   keySchedule,
  output logic                    busy,
  output logic                    done,
  output logic [0:127]            cipher
);

  if (nr != nk + 6) begin : g_cfg_check
    $error("encrypt_core: nr must equal nk + 6");
  end

  localparam logic [3:0] NrLast = 4'(nr);

  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [0:0] {StIdle, StRun} st_e;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // SubBytes fused with ShiftRows; byte index is 4*column + row.
  function automatic logic [0:127] sub_shift(input logic [0:127] s);
    logic [0:127] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[8*(4*c+r) +: 8] = sbox(s[8*(4*((c+r)%4)+r) +: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [0:127] mix_columns(input logic [0:127] s);
    logic [0:127] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c +: 8];
      a1 = s[32*c+8 +: 8];
      a2 = s[32*c+16 +: 8];
      a3 = s[32*c+24 +: 8];
      o[32*c +: 8]    = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[32*c+8 +: 8]  = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[32*c+16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[32*c+24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  st_e          st_q, st_d;
  logic [0:127] state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [0:127] cipher_q, cipher_d;

  logic [0:127] round_key;
  logic [0:127] shifted;
  logic [0:127] full_round;
  logic [0:127] final_round;

  always_comb begin
    round_key = '0;
    for (int r = 0; r <= int'(nr); r++) begin
      if (rnd_q == 4'(r)) round_key = keySchedule[128*r +: 128];
    end
  end

  assign shifted     = sub_shift(state_q);
  assign full_round  = mix_columns(shifted) ^ round_key;
  assign final_round = shifted ^ round_key;

  always_comb begin
    st_d     = st_q;
    state_d  = state_q;
    rnd_d    = rnd_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cipher_d = cipher_q;
    unique case (st_q)
      StIdle: begin
        if (start) begin
          state_d = Message ^ keySchedule[0:127];
          rnd_d   = 4'd1;
          busy_d  = 1'b1;
          st_d    = StRun;
        end
      end
      StRun: begin
        if (rnd_q == NrLast) begin
          cipher_d = final_round;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          rnd_d    = 4'd0;
          st_d     = StIdle;
        end else begin
          state_d = full_round;
          rnd_d   = rnd_q + 4'd1;
        end
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q     <= StIdle;
      state_q  <= '0;
      rnd_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cipher_q <= '0;
    end else begin
      st_q     <= st_d;
      state_q  <= state_d;
      rnd_q    <= rnd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cipher_q <= cipher_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign cipher = cipher_q;

endmodule

// File: tb/tb_encrypt_core.sv
// Directed FIPS-197 vectors against an AES-128 instance and an AES-256 instance.
// Key schedules are expanded here; expected ciphertexts are the published values.
module tb_encrypt_core;

  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] ARK_C1 = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [255:0] KEY_C3 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          start14;
  logic [0:127]  Message;
  logic [0:1407] ks10;
  logic [0:1919] ks14;
  logic          busy, done, busy14, done14;
  logic [0:127]  cipher, cipher14;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  encrypt_core #(.nk(4), .nr(10)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .Message     (Message),
    .keySchedule (ks10),
    .busy        (busy),
    .done        (done),
    .cipher      (cipher)
  );

  encrypt_core #(.nk(8), .nr(14)) u_dut14 (
    .clk         (clk),
    .reset       (reset),
    .start       (start14),
    .Message     (Message),
    .keySchedule (ks14),
    .busy        (busy14),
    .done        (done14),
    .cipher      (cipher14)
  );

  function automatic logic [7:0] sb(input logic [7:0] b);
    return SBOX[8*int'(b) +: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [0:1919] expand_key(input logic [0:255] key, input int nkw,
                                               input int nrw);
    logic [31:0]   w [0:59];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [0:1919] ks;
    ks = '0;
    rc = 8'h01;
    for (int i = 0; i < 4 * (nrw + 1); i++) begin
      if (i < nkw) begin
        w[i] = key[32*i +: 32];
      end else begin
        t = w[i-1];
        if (i % nkw == 0) begin
          t  = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])} ^ {rc, 24'h0};
          rc = xt(rc);
        end else if (nkw > 6 && i % nkw == 4) begin
          t = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])};
        end
        w[i] = w[i-nkw] ^ t;
      end
      ks[32*i +: 32] = w[i];
    end
    return ks;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Edges counted after the accepting edge until done is seen; capped at 40.
  task automatic wait_done(input bit big, output int edges, output int busy_cnt);
    edges    = 0;
    busy_cnt = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
      if (big ? busy14 : busy) busy_cnt++;
    end while (!(big ? done14 : done) && edges < 40);
  endtask

  initial begin
    logic [0:1919] full;
    int            edges, bcnt, n_done, n_busy;

    reset   = 1'b0;
    start   = 1'b0;
    start14 = 1'b0;
    Message = '0;
    ks10    = '0;
    ks14    = '0;
    #2;
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_done", 128'(done), 128'd0);
    chk("reset_cipher", cipher, 128'd0);
    chk("reset_cipher14", cipher14, 128'd0);

    full = expand_key({KEY_C1, 128'h0}, 4, 10);
    ks10 = full[0:1407];
    ks14 = expand_key(KEY_C3, 8, 14);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;

    // FIPS-197 C.1, single start pulse
    Message = PT_C1;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("c1_ark_state", u_dut.state_q, ARK_C1);
    chk("c1_busy_e0", 128'(busy), 128'd1);
    chk("c1_done_e0", 128'(done), 128'd0);
    wait_done(1'b0, edges, bcnt);
    chk("c1_latency", 128'(edges), 128'd10);
    chk("c1_busy_cycles", 128'(bcnt + 1), 128'd10);
    chk("c1_cipher", cipher, CT_C1);
    chk("c1_busy_at_done", 128'(busy), 128'd0);
    @(posedge clk);
    #1;
    chk("c1_done_width", 128'(done), 128'd0);

    // FIPS-197 appendix B; Message scrambled after acceptance
    full    = expand_key({KEY_B, 128'h0}, 4, 10);
    ks10    = full[0:1407];
    Message = PT_B;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    Message = 128'hdeadbeef_cafef00d_01234567_89abcdef;
    wait_done(1'b0, edges, bcnt);
    chk("b_latency", 128'(edges), 128'd10);
    chk("b_cipher", cipher, CT_B);

    // Idle hold with a wandering Message
    n_done = 0;
    n_busy = 0;
    repeat (50) begin
      @(posedge clk);
      #1;
      Message = {$urandom, $urandom, $urandom, $urandom};
      if (done) n_done++;
      if (busy) n_busy++;
    end
    chk("idle_cipher", cipher, CT_B);
    chk("idle_done", 128'(n_done), 128'd0);
    chk("idle_busy", 128'(n_busy), 128'd0);

    // Back-to-back with start held high throughout
    full    = expand_key({KEY_C1, 128'h0}, 4, 10);
    ks10    = full[0:1407];
    Message = PT_C1;
    start   = 1'b1;
    @(posedge clk);
    #1;
    Message = PT_B;
    wait_done(1'b0, edges, bcnt);
    chk("b2b_first_latency", 128'(edges), 128'd10);
    chk("b2b_first_cipher", cipher, CT_C1);
    full = expand_key({KEY_B, 128'h0}, 4, 10);
    ks10 = full[0:1407];
    wait_done(1'b0, edges, bcnt);
    chk("b2b_gap", 128'(edges), 128'd11);
    chk("b2b_second_cipher", cipher, CT_B);
    start  = 1'b0;
    n_done = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    chk("b2b_no_extra_done", 128'(n_done), 128'd0);
    chk("b2b_idle_busy", 128'(busy), 128'd0);

    // Asynchronous reset in round 5 of C.1
    full    = expand_key({KEY_C1, 128'h0}, 4, 10);
    ks10    = full[0:1407];
    Message = PT_C1;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("rst_mid_busy", 128'(busy), 128'd0);
    chk("rst_mid_done", 128'(done), 128'd0);
    chk("rst_mid_cipher", cipher, 128'd0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    n_done = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    chk("rst_no_done", 128'(n_done), 128'd0);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(1'b0, edges, bcnt);
    chk("rst_restart_latency", 128'(edges), 128'd10);
    chk("rst_restart_cipher", cipher, CT_C1);

    // AES-256, FIPS-197 C.3
    Message = PT_C1;
    start14 = 1'b1;
    @(posedge clk);
    #1;
    start14 = 1'b0;
    wait_done(1'b1, edges, bcnt);
    chk("c3_latency", 128'(edges), 128'd14);
    chk("c3_busy_cycles", 128'(bcnt + 1), 128'd14);
    chk("c3_cipher", cipher14, CT_C3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
